ras_spec_ctrl: RTL and testbench
================================

Name: ras_spec_ctrl

Overview:
Speculation controller for the return address stack. It converts fetch-stage call/return predictions into RAS push/pop strobes and snapshots the RAS checkpoint for every predicted control-transfer instruction (CTI) into an in-order checkpoint queue. On branch mispredict or pipeline flush it sequences the RAS recover, then replays the mispredicted CTI's own push/pop. It sits between IF, the RAS instance and the branch-resolution/commit logic.

Parameters:
RAS_DEPTH, 16, entries in the controlled RAS
PTR_BITS, $clog2(RAS_DEPTH), RAS pointer width
CKPT_W, 2*PTR_BITS+1, RAS checkpoint width
NCKPT, 8, checkpoint queue entries (power of 2)
TAG_W, $clog2(NCKPT), checkpoint tag width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
alloc_valid  in  1  IF predicts a CTI this cycle
alloc_call  in  1  CTI is a call (push)
alloc_ret  in  1  CTI is a return (pop)
alloc_ret_addr  in  32  return address to push (PC+8)
alloc_ready  out  1  queue not full and state IDLE
alloc_tag  out  TAG_W  tag assigned to this CTI (the tail index)
fetch_stall  out  1  = !alloc_ready
mp_valid  in  1  mispredict resolved
mp_tag  in  TAG_W  tag of the mispredicted CTI
flush  in  1  full pipeline flush (exception)
commit_valid  in  1  oldest CTI retires
ras_push  out  1  to RAS push
ras_pop  out  1  to RAS pop
ras_push_addr  out  32  to RAS push_addr
ras_recover  out  1  to RAS recover
ras_recover_ptr  out  CKPT_W  to RAS recover_ptr
ras_checkpoint  in  CKPT_W  current RAS state
count  out  TAG_W+1  occupied queue entries

Behaviour:
- Reset: state IDLE, head=tail=count=0. All outputs 0, except alloc_ready=1 and fetch_stall=0.
- Queue entry fields: {ckpt[CKPT_W], call, ret, ret_addr[32]}.
- Allocate (alloc_valid && alloc_ready):
  - Write entry[tail] with the pre-op ras_checkpoint sampled this cycle.
  - tail++ mod NCKPT; count++.
  - Same cycle, combinationally: ras_push=alloc_call, ras_pop=alloc_ret, ras_push_addr=alloc_ret_addr.
  - alloc_valid while !alloc_ready: ignored, no RAS strobe.
- Commit (commit_valid && count>0): head++ and count-- in any state. commit_valid with count==0 is ignored.
- Simultaneous allocate and commit: count unchanged; head and tail both advance.
- Tag validity: mp_tag is valid iff age=(mp_tag-head) mod NCKPT < count. Invalid tags are ignored.
- FSM:
  - IDLE + valid mp:
    - Latch entry[mp_tag] into recovery registers.
    - tail <= mp_tag+1; count <= age+1 (minus 1 if a commit occurs the same cycle).
    - Go to RECOVER.
  - RECOVER (one cycle): ras_recover=1, ras_recover_ptr=latched ckpt. Go to REPLAY.
  - REPLAY (one cycle): ras_push/ras_pop/ras_push_addr = latched call/ret/ret_addr. Go to IDLE.
  - A call+ret entry replays both strobes; the RAS treats that as replace-top.
  - A second valid mp in RECOVER/REPLAY that is strictly older (smaller age) re-latches, truncates tail/count, and re-enters RECOVER. Otherwise it is ignored.
  - flush in any state, with count>0: latch entry[head].ckpt, go to RECOVER, then IDLE with no replay. Queue is emptied: tail<=head, count<=0.
  - flush with count==0: queue stays empty, no recover.
  - flush has priority over mp in the same cycle.
- Latency: mp at cycle T gives ras_recover at T+1, replay at T+2, alloc_ready=1 at T+3.
- Full (count==NCKPT): alloc_ready=0. Empty: commit ignored.
- All index arithmetic is modulo NCKPT.
- ras_push/ras_pop are never asserted in RECOVER. ras_recover is never asserted with push/pop.
- rst mid-recovery: returns to IDLE immediately; queue emptied.

Decomposition:
- Package ras_pkg: RAS_DEPTH, PTR_BITS, CKPT_W constants; ras_ckpt_t typedef; ckpt_entry_t struct {ckpt, call, ret, ret_addr}; state enum {IDLE, RECOVER, REPLAY}.
- One sub-module: ckpt_queue, a circular buffer with head/tail/count, random-read port, and truncate-to-tag. The FSM and RAS strobe muxing stay in ras_spec_ctrl.

Test Plan:
- Call/return pairing: allocate call (addr 0x1008, ckpt 0) then ret. Expect ras_push then ras_pop, tags 0 and 1. Two commits leave count=0.
- Nested-call mispredict: calls at tags 0,1,2 (ckpts C0,C1,C2); mp_tag=1. Expect T+1 ras_recover with ptr=C1, T+2 ras_push with tag-1 addr, tail=2, count=2, alloc_ready high at T+3.
- Queue full: 8 allocations with no commit. Expect alloc_ready=0 and a 9th alloc producing no RAS strobe. One commit re-enables allocation; the next tag is 0 (wrap-around).
- Older mispredict during recovery: mp_tag=3, then mp_tag=1 during RECOVER. Expect recover restarted with ckpt[1] and count=2. A younger mp_tag=5 at the same point is ignored.
- Flush with 3 in-flight entries (head=6, wrapped): expect a single ras_recover with ckpt[6], no replay strobe, count=0. Flush when empty produces no recover.
- Simultaneous mp and commit of head in the same cycle: count is updated correctly. Invalid mp_tag (age ≥ count) produces no action.

Source files
------------

// File: rtl/ras_spec_ctrl_pkg.sv
// Shared types and sizing for the RAS speculation controller and its checkpoint queue.
package ras_pkg;

    localparam int RAS_DEPTH = 16;
    localparam int PTR_BITS  = $clog2(RAS_DEPTH);
    localparam int CKPT_W    = 2*PTR_BITS+1;
    localparam int NCKPT     = 8;
    localparam int TAG_W     = $clog2(NCKPT);

    typedef logic [CKPT_W-1:0] ras_ckpt_t;
    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [TAG_W:0]    cnt_t;

    typedef struct packed {
        ras_ckpt_t   ckpt;
        logic        call;
        logic        ret;
        logic [31:0] ret_addr;
    } ckpt_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECOVER,
        ST_REPLAY
    } state_t;

    // Distance of a tag from the queue head; wraps naturally at NCKPT.
    function automatic tag_t tag_age(input tag_t tag, input tag_t head);
        return tag - head;
    endfunction

endpackage

// File: rtl/ras_spec_ctrl_if.sv
// Fetch, resolution/commit and RAS-side signals of the speculation controller.
interface ras_spec_ctrl_if;
    import ras_pkg::*;

    logic        alloc_valid;
    logic        alloc_call;
    logic        alloc_ret;
    logic [31:0] alloc_ret_addr;
    logic        alloc_ready;
    tag_t        alloc_tag;
    logic        fetch_stall;
    logic        mp_valid;
    tag_t        mp_tag;
    logic        flush;
    logic        commit_valid;
    logic        ras_push;
    logic        ras_pop;
    logic [31:0] ras_push_addr;
    logic        ras_recover;
    ras_ckpt_t   ras_recover_ptr;
    ras_ckpt_t   ras_checkpoint;
    cnt_t        count;

    modport master (
        output alloc_valid, alloc_call, alloc_ret, alloc_ret_addr,
        output mp_valid, mp_tag, flush, commit_valid, ras_checkpoint,
        input  alloc_ready, alloc_tag, fetch_stall,
        input  ras_push, ras_pop, ras_push_addr, ras_recover, ras_recover_ptr, count
    );

    modport slave (
        input  alloc_valid, alloc_call, alloc_ret, alloc_ret_addr,
        input  mp_valid, mp_tag, flush, commit_valid, ras_checkpoint,
        output alloc_ready, alloc_tag, fetch_stall,
        output ras_push, ras_pop, ras_push_addr, ras_recover, ras_recover_ptr, count
    );

endinterface

// File: rtl/ras_spec_ctrl_ckpt_queue.sv
// In-order circular checkpoint queue: one entry per predicted CTI, with
// random read by tag, truncate-after-tag and full clear.
module ckpt_queue
    import ras_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  ckpt_entry_t wr_entry,
    input  logic        commit_en,
    input  logic        trunc_en,
    input  tag_t        trunc_tag,
    input  logic        clear_en,
    input  tag_t        rd_tag,
    output ckpt_entry_t rd_entry,
    output tag_t        head,
    output tag_t        tail,
    output cnt_t        count
);

    ckpt_entry_t mem [NCKPT];

    tag_t head_q, head_d;
    tag_t tail_q, tail_d;
    cnt_t count_q, count_d;
    logic commit_fire;
    logic wr_fire;
    cnt_t trunc_len;

    // Truncate and clear win over a same-cycle write; commit always applies.
    always_comb begin
        commit_fire = commit_en && (count_q != '0);
        wr_fire     = wr_en && !trunc_en && !clear_en && (count_q != cnt_t'(NCKPT));
        trunc_len   = cnt_t'(tag_age(trunc_tag, head_q)) + cnt_t'(1);
        head_d      = head_q + tag_t'(commit_fire);
        tail_d      = tail_q;
        count_d     = count_q;
        if (clear_en) begin
            tail_d  = head_d;
            count_d = '0;
        end else if (trunc_en) begin
            tail_d  = trunc_tag + tag_t'(1);
            count_d = trunc_len - cnt_t'(commit_fire);
        end else begin
            tail_d  = tail_q + tag_t'(wr_fire);
            count_d = count_q + cnt_t'(wr_fire) - cnt_t'(commit_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[tail_q] <= wr_entry;
        end
    end

    assign rd_entry = mem[rd_tag];
    assign head     = head_q;
    assign tail     = tail_q;
    assign count    = count_q;

endmodule

// File: rtl/ras_spec_ctrl.sv
// RAS speculation controller: turns call/return predictions into RAS strobes,
// checkpoints each CTI, and sequences recover + replay on mispredict or flush.
module ras_spec_ctrl
    import ras_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    ras_spec_ctrl_if.slave bus
);

    state_t      state_q, state_d;
    ckpt_entry_t rec_q, rec_d;
    logic        replay_q, replay_d;

    tag_t        head, tail, mp_age, rd_tag;
    cnt_t        count;
    ckpt_entry_t rd_entry, wr_entry;
    logic        alloc_ready, alloc_fire;
    logic        mp_ok, mp_take, flush_ok;
    logic        replaying;

    always_comb begin
        alloc_ready = (state_q == ST_IDLE) && (count != cnt_t'(NCKPT));
        alloc_fire  = bus.alloc_valid && alloc_ready && !rst;
        wr_entry    = '{ckpt: bus.ras_checkpoint, call: bus.alloc_call,
                        ret: bus.alloc_ret, ret_addr: bus.alloc_ret_addr};
        mp_age      = tag_age(bus.mp_tag, head);
        mp_ok       = bus.mp_valid && (cnt_t'(mp_age) < count);
        // While recovering, the CTI being recovered is the youngest entry, so
        // only a strictly older tag may restart recovery.
        mp_take     = mp_ok && ((state_q == ST_IDLE) ||
                                (cnt_t'(mp_age) + cnt_t'(1) < count));
        flush_ok    = bus.flush && (count != '0);
        rd_tag      = flush_ok ? head : bus.mp_tag;
    end

    ckpt_queue u_queue (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (alloc_fire),
        .wr_entry  (wr_entry),
        .commit_en (bus.commit_valid),
        .trunc_en  (mp_take && !flush_ok),
        .trunc_tag (bus.mp_tag),
        .clear_en  (flush_ok),
        .rd_tag    (rd_tag),
        .rd_entry  (rd_entry),
        .head      (head),
        .tail      (tail),
        .count     (count)
    );

    always_comb begin
        state_d  = state_q;
        rec_d    = rec_q;
        replay_d = replay_q;
        if (flush_ok) begin
            rec_d    = rd_entry;
            replay_d = 1'b0;
            state_d  = ST_RECOVER;
        end else if (mp_take) begin
            rec_d    = rd_entry;
            replay_d = 1'b1;
            state_d  = ST_RECOVER;
        end else begin
            case (state_q)
                ST_RECOVER: state_d = replay_q ? ST_REPLAY : ST_IDLE;
                ST_REPLAY:  state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rec_q    <= '0;
            replay_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rec_q    <= rec_d;
            replay_q <= replay_d;
        end
    end

    assign replaying           = (state_q == ST_REPLAY);
    assign bus.alloc_ready     = alloc_ready;
    assign bus.fetch_stall     = !alloc_ready;
    assign bus.alloc_tag       = tail;
    assign bus.count           = count;
    assign bus.ras_recover     = (state_q == ST_RECOVER);
    assign bus.ras_recover_ptr = (state_q == ST_RECOVER) ? rec_q.ckpt : '0;
    assign bus.ras_push        = replaying ? rec_q.call : (alloc_fire && bus.alloc_call);
    assign bus.ras_pop         = replaying ? rec_q.ret  : (alloc_fire && bus.alloc_ret);
    assign bus.ras_push_addr   = replaying  ? rec_q.ret_addr :
                                 alloc_fire ? bus.alloc_ret_addr : 32'h0;

endmodule

// File: tb/tb_ras_spec_ctrl.sv
// Bench for ras_spec_ctrl: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ras_spec_ctrl;
    import ras_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ras_spec_ctrl_if bus ();

    ras_spec_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: in-flight CTIs oldest-first plus a schedule of the
    // cycles at which recover, replay and re-enabled fetch must appear.
    typedef struct {
        logic [8:0]  ck;
        logic        call;
        logic        ret;
        logic [31:0] addr;
    } m_entry_t;

    m_entry_t mq[$];
    m_entry_t rec_e, rep_e;
    int m_head = 0, cyc = 0, rec_at = -1, rep_at = -1, ready_at = 0;

    always @(negedge clk) begin : model_cmp
        int size, age;
        logic exp_ready, exp_fire, take, fl_ok, cm;
        m_entry_t ne;
        cyc++;
        if (rst) begin
            mq.delete();
            m_head   = 0;
            rec_at   = -1;
            rep_at   = -1;
            ready_at = cyc + 1;
        end else begin
            size      = mq.size();
            exp_ready = (cyc >= ready_at) && (size < NCKPT);
            exp_fire  = bus.alloc_valid && exp_ready;
            check_output("m_ready", bus.alloc_ready, exp_ready);
            check_output("m_stall", bus.fetch_stall, !exp_ready);
            check_output("m_count", bus.count, size);
            check_output("m_tag", bus.alloc_tag, (m_head + size) % NCKPT);
            check_output("m_push", bus.ras_push,
                         (cyc == rep_at) ? rep_e.call : (exp_fire && bus.alloc_call));
            check_output("m_pop", bus.ras_pop,
                         (cyc == rep_at) ? rep_e.ret : (exp_fire && bus.alloc_ret));
            check_output("m_addr", bus.ras_push_addr,
                         (cyc == rep_at) ? rep_e.addr : (exp_fire ? bus.alloc_ret_addr : 32'h0));
            check_output("m_recover", bus.ras_recover, cyc == rec_at);
            check_output("m_rptr", bus.ras_recover_ptr, (cyc == rec_at) ? rec_e.ck : 9'h0);

            age   = (int'(bus.mp_tag) - m_head + NCKPT) % NCKPT;
            take  = bus.mp_valid && (age < size) && ((cyc >= ready_at) || (age < size - 1));
            fl_ok = bus.flush && (size > 0);
            cm    = bus.commit_valid && (size > 0);
            if (fl_ok) begin
                rec_e    = mq[0];
                rec_at   = cyc + 1;
                rep_at   = -1;
                ready_at = cyc + 2;
                mq.delete();
                if (cm) m_head = (m_head + 1) % NCKPT;
            end else if (take) begin
                rec_e    = mq[age];
                rep_e    = mq[age];
                rec_at   = cyc + 1;
                rep_at   = cyc + 2;
                ready_at = cyc + 3;
                while (mq.size() > age + 1) void'(mq.pop_back());
                if (cm) begin
                    void'(mq.pop_front());
                    m_head = (m_head + 1) % NCKPT;
                end
            end else begin
                if (exp_fire) begin
                    ne.ck   = bus.ras_checkpoint;
                    ne.call = bus.alloc_call;
                    ne.ret  = bus.alloc_ret;
                    ne.addr = bus.alloc_ret_addr;
                    mq.push_back(ne);
                end
                if (cm) begin
                    void'(mq.pop_front());
                    m_head = (m_head + 1) % NCKPT;
                end
            end
        end
    end

    task automatic apply_stimulus(input logic av, input logic c, input logic r,
                                  input logic [31:0] a, input logic [8:0] ck,
                                  input logic mv, input logic [2:0] mt,
                                  input logic fl, input logic cm);
        @(posedge clk);
        #1;
        bus.alloc_valid    = av;
        bus.alloc_call     = c;
        bus.alloc_ret      = r;
        bus.alloc_ret_addr = a;
        bus.ras_checkpoint = ck;
        bus.mp_valid       = mv;
        bus.mp_tag         = mt;
        bus.flush          = fl;
        bus.commit_valid   = cm;
        @(negedge clk);
    endtask

    task automatic nop();
        apply_stimulus(0, 0, 0, 32'h0, 9'h0, 0, 3'd0, 0, 0);
    endtask

    task automatic alloc(input logic c, input logic r, input logic [31:0] a, input logic [8:0] ck);
        apply_stimulus(1, c, r, a, ck, 0, 3'd0, 0, 0);
    endtask

    task automatic mp(input logic [2:0] t, input logic cm);
        apply_stimulus(0, 0, 0, 32'h0, 9'h0, 1, t, 0, cm);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.alloc_valid = 0; bus.alloc_call = 0; bus.alloc_ret = 0; bus.alloc_ret_addr = 0;
        bus.ras_checkpoint = 0; bus.mp_valid = 0; bus.mp_tag = 0; bus.flush = 0; bus.commit_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.alloc_valid = 0; bus.alloc_call = 0; bus.alloc_ret = 0; bus.alloc_ret_addr = 0;
        bus.ras_checkpoint = 0; bus.mp_valid = 0; bus.mp_tag = 0; bus.flush = 0; bus.commit_valid = 0;

        // Reset state and call/return pairing
        do_reset();
        check_output("rst_ready", bus.alloc_ready, 1);
        check_output("rst_stall", bus.fetch_stall, 0);
        check_output("rst_count", bus.count, 0);
        check_output("rst_recover", bus.ras_recover, 0);
        alloc(1, 0, 32'h1008, 9'h000);
        check_output("pair_push", bus.ras_push, 1);
        check_output("pair_addr", bus.ras_push_addr, 32'h1008);
        check_output("pair_tag0", bus.alloc_tag, 0);
        alloc(0, 1, 32'h0, 9'h001);
        check_output("pair_pop", bus.ras_pop, 1);
        check_output("pair_tag1", bus.alloc_tag, 1);
        apply_stimulus(0, 0, 0, 32'h0, 9'h0, 0, 3'd0, 0, 1);
        check_output("pair_cnt2", bus.count, 2);
        apply_stimulus(0, 0, 0, 32'h0, 9'h0, 0, 3'd0, 0, 1);
        nop();
        check_output("pair_cnt0", bus.count, 0);

        // Nested-call mispredict on tag 1
        do_reset();
        alloc(1, 0, 32'h100, 9'h010);
        alloc(1, 0, 32'h200, 9'h021);
        alloc(1, 0, 32'h300, 9'h032);
        mp(3'd1, 0);
        check_output("nest_cnt3", bus.count, 3);
        nop();
        check_output("nest_rec", bus.ras_recover, 1);
        check_output("nest_ptr", bus.ras_recover_ptr, 9'h021);
        check_output("nest_nopush", bus.ras_push, 0);
        check_output("nest_cnt2", bus.count, 2);
        nop();
        check_output("nest_replay", bus.ras_push, 1);
        check_output("nest_raddr", bus.ras_push_addr, 32'h200);
        check_output("nest_norec", bus.ras_recover, 0);
        nop();
        check_output("nest_ready", bus.alloc_ready, 1);
        check_output("nest_tag", bus.alloc_tag, 2);

        // Queue full and wrap-around
        do_reset();
        for (int i = 0; i < 8; i++) alloc(1, 0, 32'h1000 + 32'(i * 8), 9'(i));
        nop();
        check_output("full_ready", bus.alloc_ready, 0);
        check_output("full_stall", bus.fetch_stall, 1);
        check_output("full_cnt", bus.count, 8);
        alloc(1, 1, 32'hdead, 9'h0aa);
        check_output("full_nopush", bus.ras_push, 0);
        check_output("full_nopop", bus.ras_pop, 0);
        apply_stimulus(0, 0, 0, 32'h0, 9'h0, 0, 3'd0, 0, 1);
        alloc(1, 0, 32'h5000, 9'h003);
        check_output("wrap_ready", bus.alloc_ready, 1);
        check_output("wrap_tag", bus.alloc_tag, 0);
        check_output("wrap_push", bus.ras_push, 1);
        nop();
        check_output("wrap_cnt", bus.count, 8);

        // Older mispredict during recovery restarts it; younger/equal ignored
        do_reset();
        for (int i = 0; i < 6; i++) alloc(1, i == 1, 32'h2000 + 32'(i * 4), 9'h040 + 9'(i));
        mp(3'd3, 0);
        check_output("old_cnt6", bus.count, 6);
        mp(3'd1, 0);
        check_output("old_rec1", bus.ras_recover, 1);
        check_output("old_ptr3", bus.ras_recover_ptr, 9'h043);
        check_output("old_cnt4", bus.count, 4);
        mp(3'd5, 0);
        check_output("old_rec2", bus.ras_recover, 1);
        check_output("old_ptr1", bus.ras_recover_ptr, 9'h041);
        check_output("old_cnt2", bus.count, 2);
        mp(3'd1, 0);
        check_output("old_rpush", bus.ras_push, 1);
        check_output("old_rpop", bus.ras_pop, 1);
        check_output("old_raddr", bus.ras_push_addr, 32'h2004);
        nop();
        check_output("old_ready", bus.alloc_ready, 1);
        check_output("old_tag", bus.alloc_tag, 2);

        // Flush with wrapped head=6 and three in flight, then flush when empty
        do_reset();
        for (int i = 0; i < 6; i++) alloc(1, 0, 32'h600 + 32'(i), 9'(i));
        for (int i = 0; i < 6; i++) apply_stimulus(0, 0, 0, 32'h0, 9'h0, 0, 3'd0, 0, 1);
        alloc(1, 0, 32'h7000, 9'h066);
        check_output("fl_tag6", bus.alloc_tag, 6);
        alloc(0, 1, 32'h0, 9'h077);
        alloc(1, 0, 32'h7008, 9'h100);
        check_output("fl_tag0", bus.alloc_tag, 0);
        apply_stimulus(0, 0, 0, 32'h0, 9'h0, 0, 3'd0, 1, 0);
        check_output("fl_cnt3", bus.count, 3);
        nop();
        check_output("fl_rec", bus.ras_recover, 1);
        check_output("fl_ptr", bus.ras_recover_ptr, 9'h066);
        check_output("fl_cnt0", bus.count, 0);
        nop();
        check_output("fl_noreplay", bus.ras_push | bus.ras_pop, 0);
        check_output("fl_ready", bus.alloc_ready, 1);
        check_output("fl_tag", bus.alloc_tag, 6);
        apply_stimulus(0, 0, 0, 32'h0, 9'h0, 0, 3'd0, 1, 0);
        nop();
        check_output("fl_empty_norec", bus.ras_recover, 0);

        // Mispredict with same-cycle commit, invalid tags, alloc+commit
        do_reset();
        for (int i = 0; i < 4; i++) alloc(1, 0, 32'h3000 + 32'(i * 4), 9'h080 + 9'(i));
        mp(3'd2, 1);
        nop();
        check_output("mc_ptr", bus.ras_recover_ptr, 9'h082);
        check_output("mc_cnt", bus.count, 2);
        nop();
        check_output("mc_raddr", bus.ras_push_addr, 32'h3008);
        nop();
        check_output("mc_tag", bus.alloc_tag, 3);
        mp(3'd0, 0);
        nop();
        check_output("inv_norec0", bus.ras_recover, 0);
        mp(3'd3, 0);
        nop();
        check_output("inv_norec3", bus.ras_recover, 0);
        apply_stimulus(1, 1, 0, 32'h4000, 9'h1ff, 0, 3'd0, 0, 1);
        check_output("ac_push", bus.ras_push, 1);
        nop();
        check_output("ac_cnt", bus.count, 2);
        check_output("ac_tag", bus.alloc_tag, 4);

        // Reset in the middle of recovery
        mp(3'd2, 0);
        nop();
        check_output("mr_rec", bus.ras_recover, 1);
        do_reset();
        check_output("mr_ready", bus.alloc_ready, 1);
        check_output("mr_cnt", bus.count, 0);
        check_output("mr_norec", bus.ras_recover, 0);
        nop();
        check_output("mr_nopush", bus.ras_push, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
